// File: rtl/ifetch_queue_if.sv
// Fetch bus bundle between ifetch_queue and instruction memory.
// Master raises re/sel/addr and holds them; slave answers with ack/instr.
interface ifetch_queue_if #(
  parameter int unsigned XLEN = 32
);
  logic              re;
  logic [XLEN/8-1:0] sel;
  logic [XLEN-1:0]   addr;
  logic              ack;
  logic [31:0]       instr;

  modport master (
    output re, sel, addr,
    input  ack, instr
  );

  modport slave (
    input  re, sel, addr,
    output ack, instr
  );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch unit: one-outstanding bus fetcher feeding a small FIFO.
// Optional IFQ_MISALIGN_TRAP_EN traps misaligned redirect targets.
module ifetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  ifetch_queue_if.master  bus,
  input  logic            stall,
  input  logic            je,
  input  logic [XLEN-1:0] ja,
  output logic            valid_out,
  output logic [29:0]     instr_out,
  output logic [XLEN-1:0] curr_pc,
  output logic [XLEN-1:0] inc_pc,
  output logic            fault
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    KILL = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic              re_q, re_d;
  logic [XLEN/8-1:0] sel_q, sel_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic              epoch_q, epoch_d;
  logic              req_ep_q, req_ep_d;
  logic [AW-1:0]     wr_q, wr_d;
  logic [AW-1:0]     rd_q, rd_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [29:0]     ins_mem [DEPTH];
  logic [XLEN-1:0] pc_mem  [DEPTH];

  logic [XLEN-1:0] ja_al;
  logic [XLEN-1:0] nxt_pc;
  logic            fault_d;
  logic            push;
  logic            pop;
  logic            can_raise;
  logic            raise;
  logic            instr_unused;

  assign ja_al  = {ja[XLEN-1:2], 2'b00};
  assign nxt_pc = je ? ja_al : fetch_pc_q;

`ifdef IFQ_MISALIGN_TRAP_EN
  logic fault_q;
  logic ja_bad;

  // A misaligned target parks the fetcher until an aligned redirect.
  assign ja_bad  = |ja[1:0];
  assign fault_d = je ? ja_bad : fault_q;
  assign fault   = fault_q;

  always_ff @(posedge clk) begin
    if (!reset_n) fault_q <= 1'b0;
    else          fault_q <= fault_d;
  end
`else
  logic ja_unused;

  assign ja_unused = ^ja[1:0];
  assign fault_d   = 1'b0;
  assign fault     = 1'b0;
`endif

  assign instr_unused = ^bus.instr[1:0];

  // Only current-epoch words from a live request are kept.
  assign push = bus.ack && (state_q == REQ)
             && (req_ep_q == epoch_q) && !je;
  assign pop  = valid_out && !stall && !je;

  assign cnt_d = je ? '0
               : cnt_q + CW'(push) - CW'(pop);
  assign wr_d  = je ? '0 : wr_q + AW'(push);
  assign rd_d  = je ? '0 : rd_q + AW'(pop);

  assign can_raise = !fault_d && (cnt_d < CW'(DEPTH));

  assign epoch_d = epoch_q
                 ^ (je && (state_q == REQ) && !bus.ack);

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (can_raise) state_d = REQ;
      end
      REQ: begin
        if (bus.ack)  state_d = can_raise ? REQ : IDLE;
        else if (je)  state_d = KILL;
      end
      KILL: begin
        if (bus.ack) state_d = can_raise ? REQ : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign raise = (state_d == REQ)
              && ((state_q == IDLE) || bus.ack);

  always_comb begin
    re_d       = re_q;
    sel_d      = sel_q;
    addr_d     = addr_q;
    fetch_pc_d = je ? ja_al : fetch_pc_q;
    req_ep_d   = req_ep_q;
    if (raise) begin
      re_d       = 1'b1;
      sel_d      = '1;
      addr_d     = nxt_pc;
      fetch_pc_d = nxt_pc + XLEN'(4);
      req_ep_d   = epoch_d;
    end else if (state_d == IDLE) begin
      re_d  = 1'b0;
      sel_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      re_q       <= 1'b0;
      sel_q      <= '0;
      addr_q     <= '0;
      fetch_pc_q <= RESET_PC;
      epoch_q    <= 1'b0;
      req_ep_q   <= 1'b0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
    end else begin
      re_q       <= re_d;
      sel_q      <= sel_d;
      addr_q     <= addr_d;
      fetch_pc_q <= fetch_pc_d;
      epoch_q    <= epoch_d;
      req_ep_q   <= req_ep_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ins_mem[wr_q] <= bus.instr[31:2];
      pc_mem[wr_q]  <= addr_q;
    end
  end

  assign bus.re   = re_q;
  assign bus.sel  = sel_q;
  assign bus.addr = addr_q;

  assign valid_out = (cnt_q != '0);
  assign instr_out = ins_mem[rd_q];
  assign curr_pc   = pc_mem[rd_q];
  assign inc_pc    = curr_pc + XLEN'(4);

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: memory responder, PC-stream scoreboard and
// directed scenarios; define IFQ_MISALIGN_TRAP_EN to cover the trap.
module tb_ifetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall;
  logic        je;
  logic [31:0] ja;
  logic        valid_out;
  logic [29:0] instr_out;
  logic [31:0] curr_pc;
  logic [31:0] inc_pc;
  logic        fault;

  ifetch_queue_if #(.XLEN(32)) bus();

  ifetch_queue #(
    .XLEN(32), .DEPTH(DEPTH), .RESET_PC(RPC)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .stall(stall), .je(je), .ja(ja),
    .valid_out(valid_out), .instr_out(instr_out),
    .curr_pc(curr_pc), .inc_pc(inc_pc), .fault(fault)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] nreq_pc;
  logic [31:0] out_addr;
  logic [31:0] je_tgt;
  bit          out_pend, out_kill, fault_m;
  bit          je_at_ack, force_ack;
  int          wait_cnt, lat, ack_cnt;

  function automatic logic [31:0] fw(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  // One cycle: compare outputs, answer the bus, advance the model.
  task automatic step();
    bit ack_v, pop, acc;
    ack_v = 1'b0;
    if (reset_n) begin
      chk("valid", 32'(valid_out), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        chk("head_pc", curr_pc, exp_q[0]);
        chk("head_ins", 32'(instr_out), fw(exp_q[0]) >> 2);
        chk("inc_pc", inc_pc, exp_q[0] + 32'd4);
      end
      chk("fault", 32'(fault), 32'(fault_m));
      if (bus.re) begin
        if (!out_pend) begin
          chk("req_addr", bus.addr, nreq_pc);
          chk("req_sel", 32'(bus.sel), 32'hF);
          chk("req_room",
              32'(exp_q.size() < DEPTH && !fault_m), 32'd1);
          out_pend = 1'b1;
          out_kill = 1'b0;
          out_addr = nreq_pc;
          nreq_pc  = nreq_pc + 32'd4;
          wait_cnt = 0;
        end else begin
          chk("req_hold", bus.addr, out_addr);
        end
        if (wait_cnt >= lat) ack_v = 1'b1;
        else wait_cnt++;
      end else if (out_pend) begin
        chk("re_hold", 32'(bus.re), 32'd1);
      end
    end
    if (force_ack) ack_v = 1'b1;
    force_ack = 1'b0;
    if (je_at_ack && ack_v) begin
      je = 1'b1;
      ja = je_tgt;
      je_at_ack = 1'b0;
    end
    bus.ack   = ack_v;
    bus.instr = ack_v ? fw(bus.addr) : 32'hDEAD_BEEF;
    if (ack_v) ack_cnt++;
    if (!reset_n) begin
      exp_q.delete();
      out_pend = 1'b0;
      nreq_pc  = RPC;
      fault_m  = 1'b0;
    end else begin
      pop = (exp_q.size() != 0) && !stall && !je;
      acc = ack_v && out_pend && !out_kill && !je;
      if (pop) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(out_addr);
      if (ack_v) out_pend = 1'b0;
      if (je) begin
        exp_q.delete();
        if (out_pend) out_kill = 1'b1;
`ifdef IFQ_MISALIGN_TRAP_EN
        fault_m = (ja[1:0] != 2'b00);
`endif
        nreq_pc = {ja[31:2], 2'b00};
      end
    end
    @(posedge clk);
    @(negedge clk);
    bus.ack = 1'b0;
    je = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    je = 1'b0;
    stall = 1'b0;
    lat = 1;
    step();
    step();
    chk("rst_re", 32'(bus.re), 32'd0);
    chk("rst_sel", 32'(bus.sel), 32'd0);
    chk("rst_addr", bus.addr, 32'd0);
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    reset_n = 1'b1;
  endtask

  initial begin
    int n;
    reset_n = 1'b0; stall = 1'b0; je = 1'b0; ja = '0;
    bus.ack = 1'b0; bus.instr = '0;
    nreq_pc = RPC; out_addr = '0; je_tgt = '0;
    out_pend = 0; out_kill = 0; fault_m = 0;
    je_at_ack = 0; force_ack = 0;
    wait_cnt = 0; lat = 1; ack_cnt = 0;
    @(negedge clk);

    // Basic streaming, ack one cycle after each request
    do_reset();
    step();
    chk("t1_re", 32'(bus.re), 32'd1);
    chk("t1_a0", bus.addr, 32'h0);
    step(); step();
    chk("t1_valid", 32'(valid_out), 32'd1);
    chk("t1_pc", curr_pc, 32'h0);
    chk("t1_inc", inc_pc, 32'h4);
    chk("t1_a4", bus.addr, 32'h4);
    step(); step();
    chk("t1_a8", bus.addr, 32'h8);

    // Continuous stall fills exactly DEPTH entries
    do_reset();
    stall = 1'b1;
    ack_cnt = 0;
    repeat (30) step();
    chk("t2_acks", 32'(ack_cnt), 32'd4);
    chk("t2_re", 32'(bus.re), 32'd0);
    chk("t2_pc", curr_pc, 32'h0);
    chk("t2_inc", inc_pc, 32'h4);

    // Redirect while the request to 0x8 is outstanding
    do_reset();
    n = 0;
    while (!(bus.re && bus.addr == 32'h8) && n < 20) begin
      step(); n++;
    end
    chk("t3_to8", 32'(n < 20), 32'd1);
    lat = 3;
    je = 1'b1; ja = 32'h100;
    step();
    chk("t3_flush", 32'(valid_out), 32'd0);
    n = 0;
    while (bus.addr == 32'h8 && n < 20) begin
      step(); n++;
    end
    chk("t3_a100", bus.addr, 32'h100);
    n = 0;
    while (!valid_out && n < 20) begin
      step(); n++;
    end
    chk("t3_pc", curr_pc, 32'h100);

    // Redirect on the same cycle as ack
    do_reset();
    repeat (6) step();
    je_tgt = 32'h40;
    je_at_ack = 1'b1;
    n = 0;
    while (je_at_ack && n < 10) begin
      step(); n++;
    end
    chk("t4_hit", 32'(je_at_ack), 32'd0);
    je_at_ack = 1'b0;
    chk("t4_flush", 32'(valid_out), 32'd0);
    n = 0;
    while (!valid_out && n < 20) begin
      step(); n++;
    end
    chk("t4_pc", curr_pc, 32'h40);

    // PC wrap at the top of the address space
    do_reset();
    lat = 0;
    je = 1'b1; ja = 32'hFFFF_FFF8;
    step();
    stall = 1'b1;
    repeat (8) step();
    chk("t5_h0", curr_pc, 32'hFFFF_FFF8);
    stall = 1'b0;
    step();
    stall = 1'b1;
    chk("t5_h1", curr_pc, 32'hFFFF_FFFC);
    chk("t5_inc", inc_pc, 32'h0);
    stall = 1'b0;
    step();
    chk("t5_h2", curr_pc, 32'h0);
    chk("t5_inc2", inc_pc, 32'h4);

    // Misaligned redirect target
    do_reset();
`ifdef IFQ_MISALIGN_TRAP_EN
    je = 1'b1; ja = 32'h102;
    step();
    chk("t6_flt", 32'(fault), 32'd1);
    repeat (3) step();
    chk("t6_re", 32'(bus.re), 32'd0);
    chk("t6_val", 32'(valid_out), 32'd0);
    je = 1'b1; ja = 32'h200;
    step();
    chk("t6_clr", 32'(fault), 32'd0);
    chk("t6_re1", 32'(bus.re), 32'd1);
    chk("t6_a", bus.addr, 32'h200);
`else
    je = 1'b1; ja = 32'h203;
    step();
    chk("t6_re1", 32'(bus.re), 32'd1);
    chk("t6_a", bus.addr, 32'h200);
    chk("t6_flt", 32'(fault), 32'd0);
`endif
    repeat (6) step();

    // Reset with a request in flight, stray ack afterwards
    do_reset();
    lat = 5;
    repeat (3) step();
    reset_n = 1'b0;
    step();
    chk("t7_re0", 32'(bus.re), 32'd0);
    reset_n = 1'b1;
    force_ack = 1'b1;
    step();
    chk("t7_re1", 32'(bus.re), 32'd1);
    chk("t7_a", bus.addr, 32'h0);
    chk("t7_val", 32'(valid_out), 32'd0);
    lat = 1;
    repeat (10) step();

    // Mixed stalls, latencies and redirects
    do_reset();
    for (int i = 0; i < 300; i++) begin
      stall = ($urandom_range(0, 2) == 0);
      lat = $urandom_range(0, 2);
      if ($urandom_range(0, 19) == 0) begin
        je = 1'b1;
        ja = {16'h0, 14'($urandom_range(0, 16383)), 2'b00};
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
